// File: rtl/tick_gen_multi_pkg.sv
// ---------------------------------------------------------------------------
// tick_gen_multi_pkg
//
// Shared definitions for the multi-channel tick generator:
//   - default build parameters (clock divisor, channel count, widths)
//   - channel index constants for the clock datapath
//   - default per-channel divisors used by the clock build
//   - the per-channel update action and its priority resolver
//
// No ports; imported by tick_gen_multi_if, tick_chan and tick_gen_multi.
// ---------------------------------------------------------------------------
package tick_gen_multi_pkg;

    // Default build parameters.
    localparam int DEF_CLK_FREQ = 1000;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_CH_W     = 2;

    // Channel assignment in the clock datapath.
    localparam int CH_SEC   = 0;  // seconds timing
    localparam int CH_BLINK = 1;  // display blink rate
    localparam int CH_DEB   = 2;  // debounce sample rate
    localparam int CH_SCAN  = 3;  // display scan rate

    // Divisors the clock build programs after reset, assuming a 1 kHz
    // input clock. Software writes these through the divisor port; the
    // hardware reset value of every channel is still CLK_FREQ.
    localparam int DIV_SEC   = 1000;  // 1 Hz
    localparam int DIV_BLINK = 500;   // 2 Hz tick -> 1 Hz square wave
    localparam int DIV_DEB   = 10;    // 100 Hz
    localparam int DIV_SCAN  = 2;     // 500 Hz

    // What a channel does on the next clock edge (reset is handled
    // directly in the register process and is not an action here).
    typedef enum logic [2:0] {
        ACT_CLEAR = 3'd0,  // global clear: cnt, tick and sq to zero
        ACT_LOAD  = 3'd1,  // divisor write: new div, cnt to zero, sq held
        ACT_OFF   = 3'd2,  // divisor is zero: channel parked, sq held
        ACT_HOLD  = 3'd3,  // enable low: cnt and sq held
        ACT_COUNT = 3'd4,  // enabled, below terminal count: increment
        ACT_WRAP  = 3'd5   // enabled, at terminal count: tick and toggle
    } chan_act_e;

    // Priority: clear > load > disabled divisor > enable counting.
    function automatic chan_act_e chan_action(
        input logic clr,
        input logic ld,
        input logic div_zero,
        input logic en,
        input logic at_term
    );
        chan_act_e act;
        if (clr)            act = ACT_CLEAR;
        else if (ld)        act = ACT_LOAD;
        else if (div_zero)  act = ACT_OFF;
        else if (!en)       act = ACT_HOLD;
        else if (at_term)   act = ACT_WRAP;
        else                act = ACT_COUNT;
        return act;
    endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// ---------------------------------------------------------------------------
// tick_gen_multi_if
//
// Control/observation bundle of the tick generator.
//   en      NUM_CH  per-channel count enable
//   clr     1       synchronous clear of all counters and outputs
//   wr_en   1       divisor write strobe
//   wr_ch   CH_W    channel index for the write
//   wr_div  CNT_W   new divisor value
//   tick    NUM_CH  registered 1-cycle pulse per channel
//   sq      NUM_CH  registered square wave per channel
//
// master: the controller driving enables/writes and consuming ticks.
// slave : the tick generator itself.
// ---------------------------------------------------------------------------
interface tick_gen_multi_if
    import tick_gen_multi_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int CH_W   = DEF_CH_W
);
    logic [NUM_CH-1:0] en;
    logic              clr;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;

    modport master (
        output en, clr, wr_en, wr_ch, wr_div,
        input  tick, sq
    );

    modport slave (
        input  en, clr, wr_en, wr_ch, wr_div,
        output tick, sq
    );
endinterface

// File: rtl/tick_gen_multi_chan.sv
// ---------------------------------------------------------------------------
// tick_chan
//
// One divider channel: divisor register, counter, tick pulse and square
// wave. The counter runs 0 .. div-1 and emits a tick on the edge that
// wraps it, so with en held high the tick period is exactly div cycles.
//
// Ports
//   clk     in   1      clock, all logic on posedge
//   rst     in   1      synchronous active-high reset (div <= CLK_FREQ)
//   clr     in   1      clear cnt/tick/sq, divisor kept
//   en      in   1      count enable
//   ld      in   1      load ld_div into the divisor (already gated by clr)
//   ld_div  in   CNT_W  divisor to load
//   tick    out  1      registered 1-cycle pulse
//   sq      out  1      registered square wave, toggles on every tick
// ---------------------------------------------------------------------------
module tick_chan
    import tick_gen_multi_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(CLK_FREQ);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_d;
    logic             sq_d;
    logic             at_term;
    chan_act_e        act;

    // Using >= rather than == means a divisor shrunk below the current
    // count still wraps on the next enabled edge instead of running the
    // counter all the way round. div_q == 0 makes div_q-1 wrap to all
    // ones, but that case is caught earlier as ACT_OFF.
    assign at_term = (cnt_q >= (div_q - ONE));

    always_comb begin
        act = chan_action(clr, ld, (div_q == '0), en, at_term);
    end

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq;
        case (act)
            ACT_CLEAR: begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end
            ACT_LOAD: begin
                div_d = ld_div;
                cnt_d = '0;
            end
            ACT_OFF: begin
                cnt_d = '0;
            end
            ACT_HOLD: begin
                cnt_d = cnt_q;
            end
            ACT_WRAP: begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq;
            end
            ACT_COUNT: begin
                cnt_d = cnt_q + ONE;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= RST_DIV;
            cnt_q <= '0;
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            tick  <= tick_d;
            sq    <= sq_d;
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
//
// Multi-channel programmable tick generator: NUM_CH independent dividers
// running off one clock. Every channel resets to a divisor of CLK_FREQ and
// can be reprogrammed at run time through the divisor write port.
//
// Ports
//   clk   in   1      clock, all logic on posedge
//   rst   in   1      synchronous active-high reset
//   bus   slave modport of tick_gen_multi_if (en, clr, wr_*, tick, sq)
//
// The interface instance must be built with the same NUM_CH/CNT_W/CH_W as
// this module.
// ---------------------------------------------------------------------------
module tick_gen_multi
    import tick_gen_multi_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int CH_W     = DEF_CH_W
) (
    input  logic           clk,
    input  logic           rst,
    tick_gen_multi_if.slave bus
);

    logic [NUM_CH-1:0] ld;
    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] sq_w;

    // A write in a clear cycle is dropped. An index with no matching
    // channel (wr_ch >= NUM_CH) decodes to no load at all.
    always_comb begin
        ld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ld[i] = bus.wr_en && !bus.clr && (bus.wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        tick_chan #(
            .CLK_FREQ (CLK_FREQ),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .clr    (bus.clr),
            .en     (bus.en[g]),
            .ld     (ld[g]),
            .ld_div (bus.wr_div),
            .tick   (tick_w[g]),
            .sq     (sq_w[g])
        );
    end

    assign bus.tick = tick_w;
    assign bus.sq   = sq_w;

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

    logic clk = 1'b0;
    logic rst4;
    logic rst3;
    int   checks = 0;
    int   errors = 0;
    logic sq_exp;

    always #5 clk = ~clk;

    tick_gen_multi_if #(.NUM_CH(4), .CNT_W(32), .CH_W(2)) bus4 ();
    tick_gen_multi_if #(.NUM_CH(3), .CNT_W(32), .CH_W(2)) bus3 ();

    tick_gen_multi #(.CLK_FREQ(5), .NUM_CH(4), .CNT_W(32), .CH_W(2)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    tick_gen_multi #(.CLK_FREQ(5), .NUM_CH(3), .CNT_W(32), .CH_W(2)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    // Advance one posedge; inputs set after this return are sampled on the
    // next edge, outputs read after it reflect the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst4 = 1'b1;
        rst3 = 1'b1;
        bus4.en = '0; bus4.clr = 1'b0; bus4.wr_en = 1'b0; bus4.wr_ch = '0; bus4.wr_div = '0;
        bus3.en = '0; bus3.clr = 1'b0; bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_div = '0;
        repeat (3) step();
        chk("rst_tick", 32'(bus4.tick), 32'h0);
        chk("rst_sq", 32'(bus4.sq), 32'h0);
        chk("rst3_tick", 32'(bus3.tick), 32'h0);

        // Default divisor 5: ticks on the 5th, 10th, 15th edge after release.
        rst4 = 1'b0;
        bus4.en = 4'b0001;
        sq_exp = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k % 5 == 0) sq_exp = ~sq_exp;
            chk("t1_tick0", 32'(bus4.tick[0]), 32'((k % 5) == 0));
            chk("t1_sq0", 32'(bus4.sq[0]), 32'(sq_exp));
            chk("t1_others", 32'(bus4.tick[3:1]), 32'h0);
        end
        bus4.en = 4'b0000;

        // ch2 div=1: tick every cycle once enabled, sq toggles every cycle.
        bus4.wr_en = 1'b1; bus4.wr_ch = 2'd2; bus4.wr_div = 32'd1;
        step();
        chk("t2_wr_tick", 32'(bus4.tick), 32'h0);
        bus4.wr_en = 1'b0;
        bus4.en = 4'b0100;
        sq_exp = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            sq_exp = ~sq_exp;
            chk("t2_tick2", 32'(bus4.tick[2]), 32'h1);
            chk("t2_sq2", 32'(bus4.sq[2]), 32'(sq_exp));
            chk("t2_tick0", 32'(bus4.tick[0]), 32'h0);
        end

        // clr zeroes everything (sq0 was 1 here).
        bus4.en = 4'b0000;
        bus4.clr = 1'b1;
        step();
        chk("clr_tick", 32'(bus4.tick), 32'h0);
        chk("clr_sq", 32'(bus4.sq), 32'h0);
        bus4.clr = 1'b0;

        // ch0 div=4, pause enable at cnt=2 for 7 cycles, resume.
        bus4.wr_en = 1'b1; bus4.wr_ch = 2'd0; bus4.wr_div = 32'd4;
        step();
        bus4.wr_en = 1'b0;
        bus4.en = 4'b0001;
        step();
        step();
        chk("t3_pre_pause", 32'(bus4.tick[0]), 32'h0);
        bus4.en = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t3_paused", 32'(bus4.tick[0]), 32'h0);
        end
        bus4.en = 4'b0001;
        step();
        chk("t3_resume1", 32'(bus4.tick[0]), 32'h0);
        step();
        chk("t3_resume2", 32'(bus4.tick[0]), 32'h1);
        chk("t3_sq_a", 32'(bus4.sq[0]), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_period", 32'(bus4.tick[0]), 32'(k == 4));
        end
        chk("t3_sq_b", 32'(bus4.sq[0]), 32'h0);

        // ch1 div=0 parks the channel; then div=3.
        bus4.en = 4'b0010;
        bus4.wr_en = 1'b1; bus4.wr_ch = 2'd1; bus4.wr_div = 32'd0;
        step();
        bus4.wr_en = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("t4_off_tick1", 32'(bus4.tick[1]), 32'h0);
        end
        chk("t4_off_sq1", 32'(bus4.sq[1]), 32'h0);
        bus4.wr_en = 1'b1; bus4.wr_ch = 2'd1; bus4.wr_div = 32'd3;
        step();
        chk("t4_wr_tick1", 32'(bus4.tick[1]), 32'h0);
        bus4.wr_en = 1'b0;
        sq_exp = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k % 3 == 0) sq_exp = ~sq_exp;
            chk("t4_tick1", 32'(bus4.tick[1]), 32'((k % 3) == 0));
            chk("t4_sq1", 32'(bus4.sq[1]), 32'(sq_exp));
        end

        // clr together with a write to ch0: write dropped, div0 stays 4.
        bus4.en = 4'b0011;
        step();
        step();
        bus4.clr = 1'b1;
        bus4.wr_en = 1'b1; bus4.wr_ch = 2'd0; bus4.wr_div = 32'd7;
        step();
        chk("t5_tick", 32'(bus4.tick), 32'h0);
        chk("t5_sq", 32'(bus4.sq), 32'h0);
        bus4.clr = 1'b0;
        bus4.wr_en = 1'b0;
        bus4.en = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t5_div_kept", 32'(bus4.tick[0]), 32'(k == 4));
        end
        chk("t5_sq0", 32'(bus4.sq[0]), 32'h1);
        bus4.en = 4'b0000;

        // NUM_CH=3: wr_ch=3 hits nothing; mid-count rst restores divisors.
        rst3 = 1'b0;
        bus3.en = 3'b111;
        step();
        step();
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_div = 32'd1;
        step();
        bus3.wr_en = 1'b0;
        step();
        chk("t6_badch_a", 32'(bus3.tick), 32'h0);
        step();
        chk("t6_badch_b", 32'(bus3.tick), 32'h7);
        chk("t6_badch_sq", 32'(bus3.sq), 32'h7);
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd0; bus3.wr_div = 32'd2;
        step();
        chk("t6_wr0", 32'(bus3.tick), 32'h0);
        bus3.wr_en = 1'b0;
        step();
        rst3 = 1'b1;
        step();
        chk("t6_rst_tick", 32'(bus3.tick), 32'h0);
        chk("t6_rst_sq", 32'(bus3.sq), 32'h0);
        rst3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t6_post_rst", 32'(bus3.tick), (k == 5) ? 32'h7 : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
